// File: rtl/cu_sequencer.sv
// -----------------------------------------------------------------------------
// cu_sequencer
//
// Microprogrammed control sequencer for the image-processing processor.
// Runs a fetch / decode / execute state machine and drives the datapath
// control lines cycle by cycle.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   run          in   1  start request, honoured only in IDLE
//   IR_Input     in   8  instruction register contents (opcode), used at DEC
//   flag         in   1  ALU zero flag, consulted in E0 of JMPZ
//   mem_ready    in   1  memory completes the current read/write this cycle
//   C_Bus_CU     out  5  C-bus destination code
//   B_Bus_CU     out  5  B-bus source code
//   ALU_CU       out  4  ALU opcode
//   Reg_Inc_CU   out  3  bit0 PC+1, bit1 AR+1, bit2 AC clear
//   DATA_Con_CU  out  3  000 idle, 001 read, 010 write
//   IR_Load      out  1  load IR from DR
//   halted       out  1  high in HALT
//   illegal      out  1  one-cycle pulse in E0 of an undefined opcode
// -----------------------------------------------------------------------------
module cu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] IR_Input,
  input  logic       flag,
  input  logic       mem_ready,
  output logic [4:0] C_Bus_CU,
  output logic [4:0] B_Bus_CU,
  output logic [3:0] ALU_CU,
  output logic [2:0] Reg_Inc_CU,
  output logic [2:0] DATA_Con_CU,
  output logic       IR_Load,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_DEC  = 3'd4,
    S_E0   = 3'd5,
    S_E1   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // Opcodes
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JMPZ  = 8'h05;
  localparam logic [7:0] OP_INCAR = 8'h06;
  localparam logic [7:0] OP_CLRAC = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  // Register codes shared by both buses
  localparam logic [4:0] R_PC = 5'd1;
  localparam logic [4:0] R_AR = 5'd2;
  localparam logic [4:0] R_DR = 5'd3;
  localparam logic [4:0] R_AC = 5'd4;
  localparam logic [4:0] R_R1 = 5'd5;

  // ALU codes
  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;

  // Memory control codes
  localparam logic [2:0] MEM_IDLE  = 3'b000;
  localparam logic [2:0] MEM_READ  = 3'b001;
  localparam logic [2:0] MEM_WRITE = 3'b010;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;

  // State and latched opcode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the opcode is captured only in DEC
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_F0;
        else     state_d = S_IDLE;
      end
      S_F0: state_d = S_F1;
      S_F1: begin
        if (mem_ready) state_d = S_F2;
        else           state_d = S_F1;
      end
      S_F2: state_d = S_DEC;
      S_DEC: begin
        op_d    = IR_Input;
        state_d = S_E0;
      end
      S_E0: begin
        case (op_q)
          OP_LOAD: begin
            if (mem_ready) state_d = S_E1;
            else           state_d = S_E0;
          end
          OP_STORE: state_d = S_E1;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_F0;
        endcase
      end
      S_E1: begin
        if (op_q == OP_STORE && !mem_ready) state_d = S_E1;
        else                                state_d = S_F0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Control word decode from state and latched opcode. mem_ready gates the
  // PC increment in F1 so it fires exactly once per fetch; flag selects the
  // PC<-AR transfer in E0 of JMPZ.
  always_comb begin
    C_Bus_CU    = 5'd0;
    B_Bus_CU    = 5'd0;
    ALU_CU      = ALU_PASS;
    Reg_Inc_CU  = 3'b000;
    DATA_Con_CU = MEM_IDLE;
    IR_Load     = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_F0: begin
        B_Bus_CU = R_PC;
        C_Bus_CU = R_AR;
        ALU_CU   = ALU_PASS;
      end
      S_F1: begin
        DATA_Con_CU = MEM_READ;
        if (mem_ready) Reg_Inc_CU = 3'b001;
        else           Reg_Inc_CU = 3'b000;
      end
      S_F2: IR_Load = 1'b1;
      S_E0: begin
        case (op_q)
          OP_NOP:  illegal = 1'b0;
          OP_LOAD: DATA_Con_CU = MEM_READ;
          OP_STORE: begin
            B_Bus_CU = R_AC;
            C_Bus_CU = R_DR;
          end
          OP_ADD: begin
            B_Bus_CU = R_R1;
            C_Bus_CU = R_AC;
            ALU_CU   = ALU_ADD;
          end
          OP_SUB: begin
            B_Bus_CU = R_R1;
            C_Bus_CU = R_AC;
            ALU_CU   = ALU_SUB;
          end
          OP_JMPZ: begin
            if (flag) begin
              B_Bus_CU = R_AR;
              C_Bus_CU = R_PC;
            end else begin
              B_Bus_CU = 5'd0;
              C_Bus_CU = 5'd0;
            end
          end
          OP_INCAR: Reg_Inc_CU = 3'b010;
          OP_CLRAC: Reg_Inc_CU = 3'b100;
          OP_HALT:  illegal = 1'b0;
          default:  illegal = 1'b1;
        endcase
      end
      S_E1: begin
        case (op_q)
          OP_LOAD: begin
            B_Bus_CU = R_DR;
            C_Bus_CU = R_AC;
            ALU_CU   = ALU_PASS;
          end
          OP_STORE: DATA_Con_CU = MEM_WRITE;
          default:  DATA_Con_CU = MEM_IDLE;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_sequencer
//
// Table-driven bench for cu_sequencer: each record is one clock cycle of
// inputs and the control word expected in that cycle. Inputs are driven on
// the falling edge and outputs checked 1 time unit later, before the next
// rising edge. A hand-written sequence afterwards counts PC increments and
// read cycles across a stretched fetch.
// -----------------------------------------------------------------------------
module tb_cu_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] IR_Input;
  logic       flag;
  logic       mem_ready;
  logic [4:0] C_Bus_CU;
  logic [4:0] B_Bus_CU;
  logic [3:0] ALU_CU;
  logic [2:0] Reg_Inc_CU;
  logic [2:0] DATA_Con_CU;
  logic       IR_Load;
  logic       halted;
  logic       illegal;

  cu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .IR_Input    (IR_Input),
    .flag        (flag),
    .mem_ready   (mem_ready),
    .C_Bus_CU    (C_Bus_CU),
    .B_Bus_CU    (B_Bus_CU),
    .ALU_CU      (ALU_CU),
    .Reg_Inc_CU  (Reg_Inc_CU),
    .DATA_Con_CU (DATA_Con_CU),
    .IR_Load     (IR_Load),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout: {C(5), B(5), ALU(4), RegInc(3), Data(3), IRL, halted, illegal}
  typedef struct {
    string       name;
    logic        rst;
    logic        run;
    logic [7:0]  ir;
    logic        flag;
    logic        mr;
    logic [22:0] exp;
  } vec_t;

  vec_t vec_q[$];
  int   n_cmp;
  int   n_fail;

  localparam logic [7:0]  JUNK = 8'h5A;
  localparam logic [22:0] ZERO = 23'd0;

  function automatic logic [22:0] pk(input logic [4:0] c, input logic [4:0] b,
                                     input logic [3:0] alu, input logic [2:0] ri,
                                     input logic [2:0] dc, input logic irl,
                                     input logic h, input logic il);
    return {c, b, alu, ri, dc, irl, h, il};
  endfunction

  function automatic void add(input string nm, input logic r, input logic rn,
                              input logic [7:0] ir, input logic fl, input logic mr,
                              input logic [22:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.run = rn; v.ir = ir; v.flag = fl; v.mr = mr; v.exp = e;
    vec_q.push_back(v);
  endfunction

  // Four fetch cycles with mem_ready high; run held high to show it is ignored
  function automatic void fetch(input string nm, input logic [7:0] opc);
    add({nm, "_f0"},  1'b0, 1'b1, JUNK, 1'b0, 1'b1, pk(5'd2, 5'd1, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    add({nm, "_f1"},  1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0));
    add({nm, "_f2"},  1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
    add({nm, "_dec"}, 1'b0, 1'b0, opc,  1'b0, 1'b1, ZERO);
  endfunction

  function automatic logic [22:0] outs();
    return {C_Bus_CU, B_Bus_CU, ALU_CU, Reg_Inc_CU, DATA_Con_CU, IR_Load, halted, illegal};
  endfunction

  task automatic check(input string nm, input logic [22:0] got, input logic [22:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    int inc_cnt;
    int rd_cnt;
    bit irl_seen;

    n_cmp = 0; n_fail = 0;
    rst = 1'b1; run = 1'b0; IR_Input = JUNK; flag = 1'b0; mem_ready = 1'b0;

    // ---------------- vector table ----------------
    add("reset",    1'b1, 1'b0, JUNK, 1'b0, 1'b0, ZERO);
    add("idle_a",   1'b0, 1'b0, JUNK, 1'b0, 1'b1, ZERO);
    add("idle_b",   1'b0, 1'b0, JUNK, 1'b0, 1'b0, ZERO);
    add("run_idle", 1'b0, 1'b1, JUNK, 1'b0, 1'b0, ZERO);
    // NOP
    fetch("nop", 8'h00);
    add("nop_e0",   1'b0, 1'b0, JUNK, 1'b0, 1'b1, ZERO);
    // LOAD with 5-cycle fetch wait, then 3 wait cycles in E0
    add("ld_f0",    1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd2, 5'd1, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      add("ld_f1_wait", 1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
    add("ld_f1_rdy", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0));
    add("ld_f2",     1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
    add("ld_dec",    1'b0, 1'b0, 8'h01, 1'b0, 1'b1, ZERO);
    for (int i = 0; i < 3; i++)
      add("ld_e0_wait", 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
    add("ld_e0_rdy", 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
    add("ld_e1",     1'b0, 1'b0, 8'h03, 1'b0, 1'b0, pk(5'd4, 5'd3, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    // STORE with one write wait
    fetch("st", 8'h02);
    add("st_e0",      1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd3, 5'd4, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    add("st_e1_wait", 1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0));
    add("st_e1_rdy",  1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0));
    // ALU ops, JMPZ both ways, register ops, illegal
    fetch("add", 8'h03);
    add("add_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd4, 5'd5, 4'd1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    fetch("sub", 8'h04);
    add("sub_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd4, 5'd5, 4'd2, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    fetch("jz1", 8'h05);
    add("jz1_e0", 1'b0, 1'b0, JUNK, 1'b1, 1'b1, pk(5'd1, 5'd2, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    fetch("jz0", 8'h05);
    add("jz0_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, ZERO);
    fetch("incar", 8'h06);
    add("incar_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0));
    fetch("clrac", 8'h07);
    add("clrac_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0));
    fetch("ill", 8'h3C);
    add("ill_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1));
    // Reset asserted in the middle of a fetch wait
    add("rw_f0",    1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd2, 5'd1, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    add("rw_f1",    1'b0, 1'b0, JUNK, 1'b0, 1'b0, pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
    add("rw_rst",   1'b1, 1'b0, JUNK, 1'b0, 1'b0, ZERO);
    add("rw_idle",  1'b0, 1'b0, JUNK, 1'b0, 1'b1, ZERO);
    add("rw_idle2", 1'b0, 1'b0, JUNK, 1'b0, 1'b0, ZERO);
    add("rw_run",   1'b0, 1'b1, JUNK, 1'b0, 1'b0, ZERO);
    // HALT, then held across 20 cycles with run toggling
    fetch("halt", 8'hFF);
    add("halt_e0", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, ZERO);
    for (int i = 0; i < 20; i++)
      add("halt_hold", 1'b0, i[0], JUNK, 1'b0, i[1], pk(5'd0, 5'd0, 4'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0));
    add("halt_rst",  1'b1, 1'b0, JUNK, 1'b0, 1'b0, ZERO);
    add("post_rst",  1'b0, 1'b0, JUNK, 1'b0, 1'b0, ZERO);

    // ---------------- apply table ----------------
    foreach (vec_q[k]) begin
      @(negedge clk);
      rst       = vec_q[k].rst;
      run       = vec_q[k].run;
      IR_Input  = vec_q[k].ir;
      flag      = vec_q[k].flag;
      mem_ready = vec_q[k].mr;
      #1;
      check(vec_q[k].name, outs(), vec_q[k].exp);
    end

    // ---------------- hand sequence: stretched fetch ----------------
    // Now in IDLE; issue run, then hold mem_ready low for 5 F1 cycles.
    @(negedge clk); run = 1'b1; mem_ready = 1'b0;
    @(negedge clk); run = 1'b0; #1;
    check("hs_f0", outs(), pk(5'd2, 5'd1, 4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    inc_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = (i == 5); #1;
      if (Reg_Inc_CU == 3'b001) inc_cnt++;
      if (DATA_Con_CU == 3'b001) rd_cnt++;
    end
    check_int("hs_pc_inc_count", inc_cnt, 1);
    check_int("hs_read_cycles", rd_cnt, 6);
    irl_seen = 1'b0;
    for (int i = 0; i < 4 && !irl_seen; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      if (IR_Load) irl_seen = 1'b1;
    end
    check_int("hs_ir_load_seen", int'(irl_seen), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
